// File: rtl/ls_ctrl_if.sv
// Bus bundle between the control unit, the load/store controller and data memory.
// The slave modport is the controller's view; master is the control unit plus memory.
interface ls_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic [63:0] rdata;
  logic [63:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output busy, done, misalign, rdata, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  busy, done, misalign, rdata, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/ls_ctrl.sv
// Multicycle load/store controller: sub-word loads are extracted and extended from a
// doubleword read; sub-word stores are done as read-modify-write of the whole dword.
module ls_ctrl (
  input  logic   clock,
  input  logic   reset,
  ls_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;
  logic        mem_wr_q, mem_wr_d;
  logic        bad_s;

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // Illegal encodings report as misaligned so they share the error path.
  function automatic logic is_misaligned(input logic w, input logic [2:0] f3,
                                         input logic [2:0] off);
    logic bad;
    if (w && f3[2]) begin
      bad = 1'b1;
    end else if (!w && (f3 == 3'b111)) begin
      bad = 1'b1;
    end else begin
      case (f3[1:0])
        2'b00:   bad = 1'b0;
        2'b01:   bad = off[0];
        2'b10:   bad = (off[1:0] != 2'b00);
        default: bad = (off != 3'b000);
      endcase
    end
    return bad;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] word,
                                              input logic [2:0] f3,
                                              input logic [2:0] off);
    logic [63:0] s;
    logic [63:0] r;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{56{s[7]}}, s[7:0]};
      3'b001:  r = {{48{s[15]}}, s[15:0]};
      3'b010:  r = {{32{s[31]}}, s[31:0]};
      3'b100:  r = {56'd0, s[7:0]};
      3'b101:  r = {48'd0, s[15:0]};
      3'b110:  r = {32'd0, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] word,
                                              input logic [63:0] data,
                                              input logic [1:0] sz,
                                              input logic [2:0] off);
    logic [63:0] m;
    m = size_mask(sz) << {off, 3'b000};
    return (word & ~m) | ((data << {off, 3'b000}) & m);
  endfunction

  assign bad_s = is_misaligned(bus.we, bus.funct3, bus.addr[2:0]);

  // Next-state, request latching, load extraction and store merge.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d     = bus.we;
          funct3_d = bus.funct3;
          addr_d   = bus.addr;
          wdata_d  = bus.wdata;
          if (bad_s) begin
            state_d    = RESP;
            misalign_d = 1'b1;
          end else if (bus.we && (bus.funct3 == 3'b011)) begin
            state_d     = WR;
            mem_wdata_d = bus.wdata;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD:   state_d = CAP;
      CAP: begin
        if (we_q) begin
          state_d     = WR;
          mem_wdata_d = store_merge(bus.mem_rdata, wdata_q, funct3_q[1:0], addr_q[2:0]);
        end else begin
          state_d = RESP;
          rdata_d = load_extend(bus.mem_rdata, funct3_q, addr_q[2:0]);
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they align with the state flop.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == RESP);
    mem_wr_d = (state_d == WR);
  end

  // State, latched request and registered outputs; reset aborts any access at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      rdata_q     <= 64'd0;
      mem_wdata_q <= 64'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.misalign  = misalign_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = {addr_q[63:3], 3'b000};
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ls_ctrl.sv
// Directed bench for ls_ctrl with a small synchronous-read data memory model.
module tb_ls_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  ls_ctrl_if bus();
  ls_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  logic [63:0] mem [0:31];
  int          wr_cnt  = 0;
  logic [63:0] wr_data = 64'd0;

  // Memory reloads its image while reset is low; read data lags the address by one cycle.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'd0;
      mem[2] <= 64'h8877665544332211;
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[7:3]] <= bus.mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_data <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[7:3]];
  end

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] exp;
  } ld_vec_t;

  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] d);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
    @(posedge clock); #1;
    bus.req = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int wr_at, output logic mis);
    lat = 0; wr_at = 0; mis = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (bus.mem_wr && wr_at == 0) wr_at = i;
      if (bus.done) begin
        lat = i;
        mis = bus.misalign;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", bus.misalign); end
    checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", bus.mem_wr); end
    checks++; if (bus.rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    checks++; if (bus.mem_addr !== 64'd0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    reset = 1'b1;
  endtask

  task automatic test_load();
    ld_vec_t v [7];
    int lat, wr_at, w0;
    logic mis;
    v[0] = '{3'b000, 64'h17, 64'hFFFFFFFFFFFFFF88};
    v[1] = '{3'b100, 64'h17, 64'h0000000000000088};
    v[2] = '{3'b001, 64'h16, 64'hFFFFFFFFFFFF8877};
    v[3] = '{3'b101, 64'h12, 64'h0000000000004433};
    v[4] = '{3'b010, 64'h14, 64'hFFFFFFFF88776655};
    v[5] = '{3'b110, 64'h14, 64'h0000000088776655};
    v[6] = '{3'b011, 64'h10, 64'h8877665544332211};
    for (int i = 0; i < 7; i++) begin
      w0 = wr_cnt;
      issue(1'b0, v[i].f3, v[i].a, 64'd0);
      checks++; if (bus.mem_addr !== 64'h10) begin errors++; $display("FAIL load_mem_addr[%0d]: got %h expected 10", i, bus.mem_addr); end
      wait_done(lat, wr_at, mis);
      checks++; if (lat != 3) begin errors++; $display("FAIL load_latency[%0d]: got %0d expected 3", i, lat); end
      checks++; if (bus.rdata !== v[i].exp) begin errors++; $display("FAIL load_rdata[%0d]: got %h expected %h", i, bus.rdata, v[i].exp); end
      checks++; if (mis !== 1'b0 || wr_cnt != w0) begin errors++; $display("FAIL load_side[%0d]: misalign %b writes %0d expected 0 0", i, mis, wr_cnt - w0); end
    end
  endtask

  task automatic test_sub_store();
    int lat, wr_at, w0;
    logic mis;
    w0 = wr_cnt;
    issue(1'b1, 3'b001, 64'h12, 64'h00000000AAAABBBB);
    wait_done(lat, wr_at, mis);
    checks++; if (lat != 4 || wr_at != 3) begin errors++; $display("FAIL sh_timing: done %0d wr %0d expected 4 3", lat, wr_at); end
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL sh_writes: got %0d expected 1", wr_cnt - w0); end
    checks++; if (wr_data !== 64'h88776655BBBB2211) begin errors++; $display("FAIL sh_wdata: got %h expected 88776655bbbb2211", wr_data); end
    issue(1'b1, 3'b000, 64'h15, 64'h000000000000FFCC);
    wait_done(lat, wr_at, mis);
    checks++; if (lat != 4 || mis !== 1'b0) begin errors++; $display("FAIL sb_done: latency %0d misalign %b expected 4 0", lat, mis); end
    checks++; if (wr_data !== 64'h8877CC55BBBB2211) begin errors++; $display("FAIL sb_wdata: got %h expected 8877cc55bbbb2211", wr_data); end
    issue(1'b0, 3'b011, 64'h10, 64'd0);
    wait_done(lat, wr_at, mis);
    checks++; if (bus.rdata !== 64'h8877CC55BBBB2211) begin errors++; $display("FAIL store_readback: got %h expected 8877cc55bbbb2211", bus.rdata); end
  endtask

  task automatic test_sd();
    int lat, wr_at, w0;
    logic mis;
    w0 = wr_cnt;
    issue(1'b1, 3'b011, 64'h20, 64'h0123456789ABCDEF);
    wait_done(lat, wr_at, mis);
    checks++; if (lat != 2 || wr_at != 1) begin errors++; $display("FAIL sd_timing: done %0d wr %0d expected 2 1", lat, wr_at); end
    checks++; if (wr_cnt - w0 != 1 || wr_data !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL sd_write: writes %0d data %h expected 1 0123456789abcdef", wr_cnt - w0, wr_data); end
    issue(1'b0, 3'b011, 64'h20, 64'd0);
    wait_done(lat, wr_at, mis);
    checks++; if (bus.rdata !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL sd_readback: got %h expected 0123456789abcdef", bus.rdata); end
  endtask

  task automatic test_misaligned();
    logic       w   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] f3  [4] = '{3'b010, 3'b111, 3'b001, 3'b100};
    logic [63:0] a  [4] = '{64'h12, 64'h20, 64'h13, 64'h10};
    int lat, wr_at, w0;
    logic mis;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt;
      issue(w[i], f3[i], a[i], 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done(lat, wr_at, mis);
      checks++; if (lat != 1 || mis !== 1'b1) begin errors++; $display("FAIL mis_done[%0d]: latency %0d misalign %b expected 1 1", i, lat, mis); end
      checks++; if (wr_at != 0 || wr_cnt != w0) begin errors++; $display("FAIL mis_nowrite[%0d]: wr cycle %0d writes %0d expected 0 0", i, wr_at, wr_cnt - w0); end
      checks++; if (bus.rdata !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL mis_rdata[%0d]: got %h expected 0123456789abcdef", i, bus.rdata); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, wr_at;
    logic mis;
    bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b100; bus.addr = 64'h10; bus.wdata = 64'd0;
    @(posedge clock); #1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (bus.done) begin lat = i; break; end
      @(posedge clock); #1;
    end
    checks++; if (lat != 3 || bus.rdata !== 64'h11) begin errors++; $display("FAIL b2b_first: latency %0d rdata %h expected 3 11", lat, bus.rdata); end
    bus.funct3 = 3'b000; bus.addr = 64'h17;
    @(posedge clock); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy %b expected 0", bus.busy); end
    @(posedge clock); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy %b expected 1", bus.busy); end
    bus.req = 1'b0;
    wait_done(lat, wr_at, mis);
    checks++; if (lat != 3 || bus.rdata !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL b2b_second: latency %0d rdata %h expected 3 ffffffffffffff88", lat, bus.rdata); end
  endtask

  task automatic test_reset_mid_wr();
    int lat, wr_at, w0;
    logic mis;
    logic saw_done;
    w0 = wr_cnt;
    issue(1'b1, 3'b001, 64'h12, 64'h0000000000001234);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL rst_wr_phase: mem_wr %b expected 1", bus.mem_wr); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async: mem_wr %b busy %b expected 0 0", bus.mem_wr, bus.busy); end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if (bus.done) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    if (bus.done) saw_done = 1'b1;
    checks++; if (saw_done !== 1'b0 || wr_cnt != w0) begin errors++; $display("FAIL rst_abort: done seen %b writes %0d expected 0 0", saw_done, wr_cnt - w0); end
    checks++; if (bus.rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.rdata); end
    issue(1'b0, 3'b000, 64'h17, 64'd0);
    wait_done(lat, wr_at, mis);
    checks++; if (lat != 3 || bus.rdata !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL rst_after_load: latency %0d rdata %h expected 3 ffffffffffffff88", lat, bus.rdata); end
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 64'd0; bus.wdata = 64'd0;
    test_reset();
    test_load();
    test_sub_store();
    test_sd();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
